// File: rtl/me_window_feeder_if.sv
// Row-stream handshake into the motion-estimation window feeder.
// The master drives rows, the slave (the feeder) applies back-pressure.
interface me_window_feeder_if #(
    parameter int W = 184
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/me_window_feeder.sv
// Buffers one current block plus its search window from a row stream and replays
// them on LANES lanes following the motion-estimation core's 25-cycle schedule.
module me_window_feeder #(
    parameter int LANES = 16,
    parameter int PIX_W = 8,
    parameter int BLK   = 8,
    parameter int WIN   = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    me_window_feeder_if.slave         row_if,
    output logic                      core_rst,
    output logic [LANES*BLK*PIX_W-1:0] crt_frames,
    output logic [LANES*BLK*PIX_W-1:0] pre_frames,
    output logic [4:0]                phase_cnt,
    output logic                      result_valid,
    output logic                      busy
);
    localparam int LW      = BLK * PIX_W;
    localparam int RW      = WIN * PIX_W;
    localparam int BEATS   = BLK + WIN;
    localparam int LAST_PH = WIN + 1;
    localparam int CUR_AW  = $clog2(BLK);

    typedef enum logic {FILL, RUN} state_t;

    state_t              state;
    logic [4:0]          beat_cnt;
    logic                accept;
    logic [4:0]          nxt_phase;
    logic [LANES*LW-1:0] nxt_crt;
    logic [LANES*LW-1:0] nxt_pre;

    logic [LW-1:0] cur_mem [BLK];
    logic [RW-1:0] ref_mem [WIN];

    // A beat arriving together with flush is dropped, so flush gates acceptance.
    assign accept = row_if.in_valid && row_if.in_ready && !flush;

    // NOTE: the buffers carry no reset; their contents are only read after a full fill
    // rewrites them, so a reset would cost flops and routing for nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (beat_cnt < 5'(BLK))
                cur_mem[beat_cnt[CUR_AW-1:0]] <= row_if.in_data[LW-1:0];
            else
                ref_mem[beat_cnt - 5'(BLK)] <= row_if.in_data;
        end
    end

    // Lane contents for the phase the registers will show after the next edge.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        nxt_phase = (state == RUN) ? phase_cnt + 5'd1 : 5'd0;
        nxt_crt   = '0;
        nxt_pre   = '0;
        for (int k = 0; k < LANES; k++) begin
            if (nxt_phase < 5'(BLK)) begin
                nxt_crt[k*LW +: LW] = cur_mem[nxt_phase[CUR_AW-1:0]];
                nxt_pre[k*LW +: LW] = ref_mem[nxt_phase + 5'(k)][LW-1:0];
            end else if (nxt_phase < 5'(WIN)) begin
                for (int j = 0; j < BLK; j++)
                    nxt_pre[k*LW + j*PIX_W +: PIX_W] =
                        ref_mem[5'(k) + 5'(j)][{nxt_phase, 3'b000} +: PIX_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= FILL;
            beat_cnt        <= '0;
            row_if.in_ready <= 1'b0;
            core_rst        <= 1'b1;
            crt_frames      <= '0;
            pre_frames      <= '0;
            phase_cnt       <= '0;
            result_valid    <= 1'b0;
            busy            <= 1'b0;
        end else if (flush) begin
            state           <= FILL;
            beat_cnt        <= '0;
            row_if.in_ready <= 1'b1;
            core_rst        <= 1'b1;
            crt_frames      <= '0;
            pre_frames      <= '0;
            phase_cnt       <= '0;
            result_valid    <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    row_if.in_ready <= 1'b1;
                    core_rst        <= 1'b1;
                    if (accept) begin
                        if (beat_cnt == 5'(BEATS - 1)) begin
                            // Core leaves reset in the same cycle phase 0 appears.
                            state           <= RUN;
                            beat_cnt        <= '0;
                            row_if.in_ready <= 1'b0;
                            core_rst        <= 1'b0;
                            busy            <= 1'b1;
                            phase_cnt       <= nxt_phase;
                            crt_frames      <= nxt_crt;
                            pre_frames      <= nxt_pre;
                        end else begin
                            beat_cnt <= beat_cnt + 5'd1;
                        end
                    end
                end
                RUN: begin
                    if (phase_cnt == 5'(LAST_PH)) begin
                        state           <= FILL;
                        beat_cnt        <= '0;
                        row_if.in_ready <= 1'b1;
                        core_rst        <= 1'b1;
                        crt_frames      <= '0;
                        pre_frames      <= '0;
                        phase_cnt       <= '0;
                        result_valid    <= 1'b0;
                        busy            <= 1'b0;
                    end else begin
                        phase_cnt    <= nxt_phase;
                        crt_frames   <= nxt_crt;
                        pre_frames   <= nxt_pre;
                        result_valid <= (nxt_phase == 5'(LAST_PH));
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
